// File: rtl/lbp_hist.sv
// LBP code histogram: counts codes from the LBP result write stream over one frame,
// then streams the 256 bins out over valid/ready, clearing each bin as it is read.
module lbp_hist #(
    parameter int CNT_W          = 15,
    parameter bit EXCLUDE_BORDER = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    output logic             hist_valid,
    input  logic             hist_ready,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic             overrun
);

    typedef enum logic [1:0] {ACC, DUMP, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bin [256];
    logic [7:0]       index;
    logic [7:0]       index_nxt;
    logic [6:0]       row, col;
    logic             on_border;
    logic             count_beat;
    logic             xfer;
    logic [CNT_W-1:0] cur_val;
    logic [CNT_W-1:0] inc_val;

    assign row        = lbp_addr[13:7];
    assign col        = lbp_addr[6:0];
    assign on_border  = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
    assign count_beat = lbp_valid && (state == ACC) && !(EXCLUDE_BORDER && on_border);
    assign xfer       = (state == DUMP) && hist_ready;
    assign cur_val    = bin[lbp_data];
    assign inc_val    = (cur_val == CNT_MAX) ? cur_val : cur_val + 1'b1;
    assign index_nxt  = index + 8'd1;

    assign hist_valid = (state == DUMP);
    assign hist_done  = (state == DONE);
    assign hist_bin   = index;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (finish) state_nxt = DUMP;
            DUMP:    if (xfer && (index == 8'hFF)) state_nxt = DONE;
            DONE:    if (!finish) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                bin[i] <= '0;
            end
            index      <= '0;
            hist_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (lbp_valid && (state != ACC)) begin
                overrun <= 1'b1;
            end
            case (state)
                ACC: begin
                    if (count_beat) begin
                        bin[lbp_data] <= inc_val;
                    end
                    // bin 0 may be bumped by a beat in the same cycle as finish
                    if (finish) begin
                        index      <= '0;
                        hist_count <= (count_beat && (lbp_data == 8'd0)) ? inc_val : bin[0];
                    end
                end
                DUMP: begin
                    if (xfer) begin
                        bin[index] <= '0;
                        index      <= index_nxt;
                        hist_count <= (index == 8'hFF) ? '0 : bin[index_nxt];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_hist.sv
// Directed bench for lbp_hist: three instances (border on, border off, 4-bit saturating)
// share one stimulus stream and are checked against hand-computed bin counts.
module tb_lbp_hist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_ready;

    logic        hist_valid_b, hist_done_b, overrun_b;
    logic [7:0]  hist_bin_b;
    logic [14:0] hist_count_b;
    logic        hist_valid_n, hist_done_n, overrun_n;
    logic [7:0]  hist_bin_n;
    logic [14:0] hist_count_n;
    logic        hist_valid_s, hist_done_s, overrun_s;
    logic [7:0]  hist_bin_s;
    logic [3:0]  hist_count_s;

    int n_cmp = 0;
    int n_err = 0;
    int exp_b [256];
    int exp_n [256];

    always #5 clk = ~clk;

    lbp_hist #(.CNT_W(15), .EXCLUDE_BORDER(1'b1)) dut_b (
        .clk(clk), .reset(rst_n), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid_b),
        .hist_ready(hist_ready), .hist_bin(hist_bin_b), .hist_count(hist_count_b),
        .hist_done(hist_done_b), .overrun(overrun_b)
    );

    lbp_hist #(.CNT_W(15), .EXCLUDE_BORDER(1'b0)) dut_n (
        .clk(clk), .reset(rst_n), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid_n),
        .hist_ready(hist_ready), .hist_bin(hist_bin_n), .hist_count(hist_count_n),
        .hist_done(hist_done_n), .overrun(overrun_n)
    );

    lbp_hist #(.CNT_W(4), .EXCLUDE_BORDER(1'b0)) dut_s (
        .clk(clk), .reset(rst_n), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid_s),
        .hist_ready(hist_ready), .hist_bin(hist_bin_s), .hist_count(hist_count_s),
        .hist_done(hist_done_s), .overrun(overrun_s)
    );

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
        logic        counted_b;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp;
        for (int i = 0; i < 256; i++) begin
            exp_b[i] = 0;
            exp_n[i] = 0;
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic bit interior(input logic [13:0] a);
        return (a[13:7] != 7'd0) && (a[13:7] != 7'd127) && (a[6:0] != 7'd0) && (a[6:0] != 7'd127);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_valid_b"}, int'(hist_valid_b), 0);
        chk({tag, "_valid_n"}, int'(hist_valid_n), 0);
        chk({tag, "_valid_s"}, int'(hist_valid_s), 0);
        chk({tag, "_bin_b"}, int'(hist_bin_b), 0);
        chk({tag, "_count_b"}, int'(hist_count_b), 0);
        chk({tag, "_count_s"}, int'(hist_count_s), 0);
        chk({tag, "_done_b"}, int'(hist_done_b), 0);
        chk({tag, "_done_s"}, int'(hist_done_s), 0);
        chk({tag, "_overrun_b"}, int'(overrun_b), 0);
        chk({tag, "_overrun_s"}, int'(overrun_s), 0);
    endtask

    task automatic beat(input logic [13:0] a, input logic [7:0] d);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = d;
        tick();
        lbp_valid = 1'b0;
    endtask

    // mode 0: all-zero codes; mode 1: code = addr[7:0]
    task automatic run_frame(input int mode);
        for (int a = 0; a < 16384; a++) begin
            logic [13:0] av;
            av        = 14'(a);
            lbp_valid = 1'b1;
            lbp_addr  = av;
            lbp_data  = (mode == 1) ? av[7:0] : 8'h00;
            if (mode == 1 && interior(av)) exp_b[av[7:0]]++;
            tick();
        end
        lbp_valid = 1'b0;
    endtask

    task automatic start_dump;
        finish = 1'b1;
        tick();
        chk("enter_valid_b", int'(hist_valid_b), 1);
        chk("enter_valid_s", int'(hist_valid_s), 1);
        chk("enter_bin_b", int'(hist_bin_b), 0);
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating
    task automatic run_dump(input int mode, input int stop_at);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < stop_at && cyc < 1200) begin
            hist_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            chk("dump_valid", int'(hist_valid_b & hist_valid_n & hist_valid_s), 1);
            chk("dump_bin_b", int'(hist_bin_b), idx);
            chk("dump_bin_s", int'(hist_bin_s), idx);
            chk($sformatf("count_b[%0d]", idx), int'(hist_count_b), exp_b[idx]);
            chk($sformatf("count_n[%0d]", idx), int'(hist_count_n), exp_n[idx]);
            chk($sformatf("count_s[%0d]", idx), int'(hist_count_s), sat15(exp_n[idx]));
            tick();
            if (hist_ready) idx++;
            cyc++;
        end
        hist_ready = 1'b0;
        if (idx < stop_at) chk("dump_timeout", idx, stop_at);
        if (mode == 0 && stop_at == 256) chk("dump_cycles", cyc, 256);
        if (stop_at == 256) begin
            chk("post_valid_b", int'(hist_valid_b), 0);
            chk("post_done_b", int'(hist_done_b), 1);
            chk("post_done_n", int'(hist_done_n), 1);
            chk("post_done_s", int'(hist_done_s), 1);
        end
    endtask

    task automatic end_dump;
        tick();
        chk("hold_done_b", int'(hist_done_b), 1);
        finish = 1'b0;
        tick();
        chk("release_done_b", int'(hist_done_b), 0);
        chk("release_done_s", int'(hist_done_s), 0);
        chk("release_valid_n", int'(hist_valid_n), 0);
    endtask

    initial begin
        vecs[0]  = '{14'd645,   8'h10, 1'b1};
        vecs[1]  = '{14'd645,   8'h10, 1'b1};
        vecs[2]  = '{14'd10,    8'h10, 1'b0};
        vecs[3]  = '{14'd16259, 8'h20, 1'b0};
        vecs[4]  = '{14'd1279,  8'h20, 1'b0};
        vecs[5]  = '{14'd129,   8'hFF, 1'b1};
        vecs[6]  = '{14'd16254, 8'hFF, 1'b1};
        vecs[7]  = '{14'd8192,  8'h00, 1'b0};
        vecs[8]  = '{14'd16383, 8'h00, 1'b0};
        vecs[9]  = '{14'd16256, 8'h33, 1'b0};
        vecs[10] = '{14'd128,   8'h33, 1'b0};

        rst_n = 1'b0; lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
        finish = 1'b0; hist_ready = 1'b0;
        repeat (2) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // table frame: border rule, back-to-back same bin; ready high is ignored in ACC
        clear_exp();
        hist_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            beat(vecs[i].addr, vecs[i].data);
            exp_n[vecs[i].data]++;
            if (vecs[i].counted_b) exp_b[vecs[i].data]++;
        end
        hist_ready = 1'b0;
        start_dump();
        run_dump(0, 256);
        end_dump();

        // uniform zero-code frame, with backpressure during the dump
        clear_exp();
        run_frame(0);
        exp_b[0] = 15876;
        exp_n[0] = 16384;
        start_dump();
        run_dump(1, 256);
        end_dump();

        // ramp frame
        clear_exp();
        run_frame(1);
        for (int i = 0; i < 256; i++) exp_n[i] = 64;
        start_dump();
        run_dump(0, 256);
        end_dump();

        // empty frame: every bin must have been cleared by the previous read-out
        clear_exp();
        start_dump();
        run_dump(0, 256);
        end_dump();

        // beat coincident with finish counts; beat two cycles later is dropped
        chk("overrun_pre_b", int'(overrun_b), 0);
        clear_exp();
        exp_b[8'h5A] = 1;
        exp_n[8'h5A] = 1;
        finish    = 1'b1;
        lbp_valid = 1'b1;
        lbp_addr  = 14'd200;
        lbp_data  = 8'h5A;
        tick();
        lbp_valid = 1'b0;
        chk("coinc_valid_b", int'(hist_valid_b), 1);
        chk("coinc_overrun_b", int'(overrun_b), 0);
        tick();
        beat(14'd300, 8'h5A);
        chk("late_overrun_b", int'(overrun_b), 1);
        chk("late_overrun_n", int'(overrun_n), 1);
        chk("late_overrun_s", int'(overrun_s), 1);
        run_dump(0, 256);
        end_dump();
        chk("sticky_overrun_b", int'(overrun_b), 1);

        // saturation at bin 7, then reset in the middle of the dump
        clear_exp();
        for (int i = 0; i < 20; i++) beat(14'd645, 8'h07);
        exp_b[7] = 20;
        exp_n[7] = 20;
        start_dump();
        run_dump(0, 100);
        chk("middump_bin_b", int'(hist_bin_b), 100);
        rst_n = 1'b0;
        finish = 1'b0;
        #1;
        check_idle_outputs("middump_reset");
        tick();
        rst_n = 1'b1;
        tick();

        clear_exp();
        for (int i = 0; i < 3; i++) beat(14'd645, 8'h07);
        beat(14'd0, 8'h07);
        exp_b[7] = 3;
        exp_n[7] = 4;
        start_dump();
        run_dump(0, 256);
        end_dump();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lbp_hist.md
# lbp_hist

Downstream consumer of the `LBP` stage. Snoops the `lbp_valid`/`lbp_addr`/`lbp_data` write stream that feeds the LBP result memory and accumulates a 256-bin histogram of LBP codes for one 128x128 frame. When the LBP stage raises `finish`, it streams the histogram out bin by bin over a valid/ready interface, clearing each bin as it is read.

## Interface
- `CNT_W`, 15, bin counter width; counts saturate at 2^CNT_W-1
- `EXCLUDE_BORDER`, 1, when 1 pixels with row or column equal to 0 or 127 are not counted
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `lbp_valid`  in  1  one LBP result present this cycle
- `lbp_addr`  in  14  pixel address; [13:7] row, [6:0] column
- `lbp_data`  in  8  LBP code = bin index
- `finish`  in  1  frame complete; level from the LBP stage
- `hist_valid`  out  1  `hist_bin`/`hist_count` hold a valid bin
- `hist_ready`  in  1  consumer accepts the bin this cycle
- `hist_bin`  out  8  bin index being presented
- `hist_count`  out  CNT_W  count of that bin
- `hist_done`  out  1  all 256 bins transferred; held until `finish` falls
- `overrun`  out  1  sticky; `lbp_valid` arrived outside ACC

## Operation
- Storage: 256 x CNT_W register array `bin[]`. Async reset clears all bins to 0.
- States:
  - ACC: reset state.
    - A beat is counted when `lbp_valid`=1 and the pixel is not excluded by border rule: `bin[lbp_data]` += 1, saturating at 2^CNT_W-1.
    - Back-to-back beats to the same bin each count; no hazard, single-cycle read-modify-write.
    - `finish`=1 sampled -> DUMP, index=0. A beat in the same cycle is still counted.
  - DUMP: presents `bin[index]`.
    - On `hist_valid`&&`hist_ready`, `bin[index]` <= 0 and index += 1.
    - After index 255 is accepted -> DONE.
  - DONE: `hist_done`=1. `finish`=0 sampled -> ACC.
- `lbp_valid` in DUMP or DONE: beat dropped, `overrun` <= 1. `overrun` clears only on reset.
- Reset asserted mid-operation: immediate return to ACC, all bins 0, all outputs at reset values; partial histogram discarded.

## Timing
- Reset values: `hist_valid`=0, `hist_bin`=0, `hist_count`=0, `hist_done`=0, `overrun`=0.
- Accumulate latency: a beat at edge N is visible in `bin[]` after edge N.
- ACC->DUMP: `hist_valid` rises the cycle after `finish` is first sampled high, presenting bin 0.
- Output registers:
  - `hist_bin`/`hist_count` are registered and stable while `hist_valid`=1 and `hist_ready`=0.
  - With `hist_ready` held 1, one bin transfers per cycle, no bubbles: 256 transfers in 256 cycles.
- After the bin-255 transfer edge: `hist_valid`=0 and `hist_done`=1 in the next cycle.
- `hist_done` falls the cycle after `finish`=0 is sampled; ACC resumes the same cycle, so the next beat is counted.
- `hist_ready` is ignored when `hist_valid`=0.

## Test plan
- Uniform frame: 16384 beats with `lbp_data`=0x00, addresses 0..16383, `EXCLUDE_BORDER`=1, then `finish`=1, `hist_ready`=1 -> bin 0 count 15876 (126x126), bins 1..255 count 0, `hist_done` one cycle after the last transfer.
- Border off: same stimulus, `EXCLUDE_BORDER`=0 -> bin 0 count 16384.
- Ramp data, `lbp_data`=addr[7:0], border off -> every bin count 64; a second dump after a new frame of zero beats -> all bins 0 (read-clear verified).
- Backpressure: `hist_ready` toggling 1,0,0,1 pattern during dump -> each bin index presented exactly once, `hist_count` stable while stalled, 256 transfers total.
- Beat coincident with `finish` rising (addr 200, data 0x5A) -> bin 0x5A includes it; a beat two cycles later -> dropped, `overrun`=1.
- Saturation with `CNT_W`=4: 20 beats to bin 7 -> count 15. Reset asserted mid-dump at bin 100 -> outputs at reset values immediately; new frame histogram correct.
